// File: rtl/uart_pkt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkt_pkg
// Description : Shared constants, packetizer FSM encoding and clog2 helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkt_pkg;

    localparam logic [7:0] SYNC0    = 8'hAA;
    localparam logic [7:0] SYNC1    = 8'h55;
    localparam logic [7:0] TRL_MARK = 8'h5A;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_HDR0     = 4'd1,
        ST_HDR1     = 4'd2,
        ST_HDR_CNT  = 4'd3,
        ST_PIX_WAIT = 4'd4,
        ST_PIX_HI   = 4'd5,
        ST_PIX_LO   = 4'd6,
        ST_TRL0     = 4'd7,
        ST_TRL1     = 4'd8,
        ST_TRL2     = 4'd9
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frame_packetizer_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_packetizer_if
// Description : Valid/ready byte channel from the packetizer to the UART.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_frame_packetizer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/uart_frame_packetizer_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Show-ahead synchronous FIFO, wrap-bit pointers, push+pop on full.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
    import uart_pkt_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  wire              clk,
    input  wire              rst_n,
    input  wire              push,
    input  wire  [WIDTH-1:0] wdata,
    input  wire              pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int c_AW = clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_wr_en;
    logic             w_rd_en;

    assign w_rd_en = pop & ~empty;
    // A pop in the same cycle frees the slot the push needs.
    assign w_wr_en = push & (~full | w_rd_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[c_AW-1:0]] <= wdata;
    end

    assign rdata = r_mem[r_rd_ptr[c_AW-1:0]];
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
endmodule
`default_nettype wire

// File: rtl/uart_frame_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_packetizer
// Description : Decimates an RGB565 pixel stream and frames it as UART bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_packetizer
    import uart_pkt_pkg::*;
#(
    parameter int H_SCALE    = 8,
    parameter int V_SCALE    = 8,
    parameter int OUT_W      = 80,
    parameter int OUT_H      = 60,
    parameter int FIFO_DEPTH = 256
) (
    input  wire                             clk,
    input  wire                             rst_n,
    input  wire                             frame_valid,
    input  wire                             pixel_valid,
    input  wire  [9:0]                      pixel_x,
    input  wire  [9:0]                      pixel_y,
    input  wire  [15:0]                     pixel_data,
    uart_frame_packetizer_if.master         tx,
    output logic [7:0]                      frame_count,
    output logic [7:0]                      skip_count,
    output logic                            overflow,
    output logic                            busy
);
    localparam int          c_HS     = clog2(H_SCALE);
    localparam int          c_VS     = clog2(V_SCALE);
    localparam logic [9:0]  c_X_MASK = 10'(H_SCALE - 1);
    localparam logic [9:0]  c_Y_MASK = 10'(V_SCALE - 1);
    localparam logic [31:0] c_OUT_W  = OUT_W;
    localparam logic [31:0] c_OUT_H  = OUT_H;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_fv_d;
    logic        r_armed;
    logic        r_kp_valid;
    logic [15:0] r_kp_data;
    logic [15:0] r_pix_cnt;
    logic [7:0]  r_frame_count;
    logic [7:0]  r_skip_count;
    logic        r_overflow;
    logic        r_tx_valid;
    logic [7:0]  r_tx_data;
    logic        w_rise;
    logic        w_fall;
    logic        w_keep;
    logic        w_accept;
    logic        w_pop;
    logic        w_push;
    logic        w_full;
    logic        w_empty;
    logic [15:0] w_head;
    logic        w_emit;
    logic [7:0]  w_byte;

    assign w_rise   = frame_valid & ~r_fv_d;
    assign w_fall   = ~frame_valid & r_fv_d;
    assign w_keep   = pixel_valid & frame_valid & r_armed &
                      ((pixel_x & c_X_MASK) == 10'd0) &
                      ((pixel_y & c_Y_MASK) == 10'd0) &
                      (({22'd0, pixel_x} >> c_HS) < c_OUT_W) &
                      (({22'd0, pixel_y} >> c_VS) < c_OUT_H);
    assign w_accept = r_tx_valid & tx.tx_ready;
    assign w_pop    = w_accept & (r_state == ST_PIX_LO);
    assign w_push   = r_kp_valid & (~w_full | w_pop);

    sync_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .wdata (r_kp_data),
        .pop   (w_pop),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:     if (w_rise)   w_state_next = ST_HDR0;
            ST_HDR0:     if (w_accept) w_state_next = ST_HDR1;
            ST_HDR1:     if (w_accept) w_state_next = ST_HDR_CNT;
            ST_HDR_CNT:  if (w_accept) w_state_next = ST_PIX_WAIT;
            // A pixel still in the keep register must land before the trailer.
            ST_PIX_WAIT: if (!w_empty)                    w_state_next = ST_PIX_HI;
                         else if (!r_armed && !r_kp_valid) w_state_next = ST_TRL0;
            ST_PIX_HI:   if (w_accept) w_state_next = ST_PIX_LO;
            ST_PIX_LO:   if (w_accept) w_state_next = ST_PIX_WAIT;
            ST_TRL0:     if (w_accept) w_state_next = ST_TRL1;
            ST_TRL1:     if (w_accept) w_state_next = ST_TRL2;
            ST_TRL2:     if (w_accept) w_state_next = ST_IDLE;
            default:                   w_state_next = ST_IDLE;
        endcase
    end

    // Byte for the state being entered, so tx_valid/tx_data come straight from flops.
    always_comb begin
        w_emit = 1'b1;
        w_byte = 8'h00;
        case (w_state_next)
            ST_HDR0:    w_byte = SYNC0;
            ST_HDR1:    w_byte = SYNC1;
            ST_HDR_CNT: w_byte = r_frame_count + 8'd1;
            ST_PIX_HI:  w_byte = w_head[15:8];
            ST_PIX_LO:  w_byte = w_head[7:0];
            ST_TRL0:    w_byte = TRL_MARK;
            ST_TRL1:    w_byte = r_pix_cnt[15:8];
            ST_TRL2:    w_byte = r_pix_cnt[7:0];
            default:    w_emit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fv_d        <= 1'b0;
            r_armed       <= 1'b0;
            r_kp_valid    <= 1'b0;
            r_kp_data     <= 16'd0;
            r_pix_cnt     <= 16'd0;
            r_frame_count <= 8'd0;
            r_skip_count  <= 8'd0;
            r_overflow    <= 1'b0;
            r_tx_valid    <= 1'b0;
            r_tx_data     <= 8'd0;
        end else begin
            r_fv_d     <= frame_valid;
            r_kp_valid <= w_keep;
            r_kp_data  <= pixel_data;
            if (w_rise) begin
                if (r_state == ST_IDLE)         r_armed <= 1'b1;
                else if (r_skip_count != 8'hFF) r_skip_count <= r_skip_count + 8'd1;
            end else if (w_fall) begin
                r_armed <= 1'b0;
            end
            if (w_rise && (r_state == ST_IDLE)) r_pix_cnt <= 16'd0;
            else if (w_push)                    r_pix_cnt <= r_pix_cnt + 16'd1;
            if (r_kp_valid && w_full && !w_pop) r_overflow <= 1'b1;
            if (w_accept && (r_state == ST_HDR_CNT)) r_frame_count <= r_frame_count + 8'd1;
            if (!r_tx_valid || tx.tx_ready) begin
                r_tx_valid <= w_emit;
                r_tx_data  <= w_byte;
            end
        end
    end

    assign tx.tx_valid  = r_tx_valid;
    assign tx.tx_data   = r_tx_data;
    assign frame_count  = r_frame_count;
    assign skip_count   = r_skip_count;
    assign overflow     = r_overflow;
    assign busy         = (r_state != ST_IDLE);
endmodule
`default_nettype wire
